sdram_arbiter_2m: RTL

//  Two-requester round-robin arbiter sharing the single Avalon-MM slave port of the SDRAM controller core.

---
 rtl/sdram_arbiter_2m.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter_2m.sv
// Round-robin arbiter: two requesters onto one SDRAM controller slave port; a tag FIFO routes read data back.
// A command is issued the cycle after grant, with at most one in flight; reads stall while MAX_PENDING reads are outstanding.
module sdram_arbiter_2m #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int BE_W        = 2,
  parameter int MAX_PENDING = 8
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,

  input  logic [ADDR_W-1:0]            rq0_address,
  input  logic [BE_W-1:0]              rq0_byteenable_n,
  input  logic [DATA_W-1:0]            rq0_writedata,
  input  logic                         rq0_read,
  input  logic                         rq0_write,
  output logic                         rq0_waitrequest,
  output logic [DATA_W-1:0]            rq0_readdata,
  output logic                         rq0_readdatavalid,

  input  logic [ADDR_W-1:0]            rq1_address,
  input  logic [BE_W-1:0]              rq1_byteenable_n,
  input  logic [DATA_W-1:0]            rq1_writedata,
  input  logic                         rq1_read,
  input  logic                         rq1_write,
  output logic                         rq1_waitrequest,
  output logic [DATA_W-1:0]            rq1_readdata,
  output logic                         rq1_readdatavalid,

  output logic [ADDR_W-1:0]            sdram_address,
  output logic [BE_W-1:0]              sdram_byteenable_n,
  output logic                         sdram_chipselect,
  output logic [DATA_W-1:0]            sdram_writedata,
  output logic                         sdram_read_n,
  output logic                         sdram_write_n,
  input  logic [DATA_W-1:0]            sdram_readdata,
  input  logic                         sdram_readdatavalid,
  input  logic                         sdram_waitrequest,

  output logic [$clog2(MAX_PENDING):0] pending_count,
  output logic                         err_unexpected_rdv
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state;
  logic                    owner;
  logic                    prio;
  logic [MAX_PENDING-1:0]  tag_mem;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  logic fifo_full;
  logic fifo_empty;
  logic rd0, rd1;
  logic elig0, elig1;
  logic grant_vld;
  logic grant;
  logic accept;
  logic push;
  logic pop;
  logic head;

  assign fifo_full  = (pending_count == CNT_W'(MAX_PENDING));
  assign fifo_empty = (pending_count == '0);

  // An illegal read+write request is treated as a write so that read_n/write_n never both assert.
  assign rd0 = rq0_read & ~rq0_write;
  assign rd1 = rq1_read & ~rq1_write;

  assign elig0 = rq0_write | (rq0_read & ~fifo_full);
  assign elig1 = rq1_write | (rq1_read & ~fifo_full);

  assign grant_vld = elig0 | elig1;
  assign grant     = (elig0 & elig1) ? prio : elig1;

  // A command caught by reset is abandoned, so it must not look accepted to its requester.
  assign accept = (state == ISSUE) & ~sdram_waitrequest & ~reset_reset;
  assign push   = accept & ~sdram_read_n;
  assign pop    = sdram_readdatavalid & ~fifo_empty;
  assign head   = tag_mem[rd_ptr];

  assign rq0_waitrequest   = ~(accept & ~owner);
  assign rq1_waitrequest   = ~(accept &  owner);
  assign rq0_readdata      = sdram_readdata;
  assign rq1_readdata      = sdram_readdata;
  assign rq0_readdatavalid = pop & ~head;
  assign rq1_readdatavalid = pop &  head;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state              <= IDLE;
      owner              <= 1'b0;
      prio               <= 1'b0;
      sdram_address      <= '0;
      sdram_byteenable_n <= '0;
      sdram_writedata    <= '0;
      sdram_chipselect   <= 1'b0;
      sdram_read_n       <= 1'b1;
      sdram_write_n      <= 1'b1;
      tag_mem            <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      pending_count      <= '0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner              <= grant;
            sdram_address      <= grant ? rq1_address      : rq0_address;
            sdram_byteenable_n <= grant ? rq1_byteenable_n : rq0_byteenable_n;
            sdram_writedata    <= grant ? rq1_writedata    : rq0_writedata;
            sdram_chipselect   <= 1'b1;
            sdram_read_n       <= ~(grant ? rd1 : rd0);
            sdram_write_n      <= ~(grant ? rq1_write : rq0_write);
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (!sdram_waitrequest) begin
            prio             <= ~owner;
            sdram_chipselect <= 1'b0;
            sdram_read_n     <= 1'b1;
            sdram_write_n    <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        tag_mem[wr_ptr] <= owner;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   pending_count <= pending_count + 1'b1;
        2'b01:   pending_count <= pending_count - 1'b1;
        default: pending_count <= pending_count;
      endcase

      if (sdram_readdatavalid && fifo_empty) begin
        err_unexpected_rdv <= 1'b1;
      end
    end
  end

endmodule
